mem_access_arbiter: RTL and testbench

//  Shares the single ram256x8 port between instruction fetch and load/store data requesters.

---
 rtl/mem_access_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
//   Shares one RAM port between an instruction-fetch requester and a
//   load/store data requester. One requester is granted at a time. The block
//   then runs the RAM MOV/MOC handshake, checks the transfer for alignment,
//   and aborts if the RAM never answers.
//
// Ports
//   CLK, CLR            clock, synchronous active-high reset
//   f_req/f_addr        fetch request (always a word read)
//   f_ack/f_err/f_data  fetch completion pulse, error flag, fetched word
//   d_req/d_rw/d_type   data request, 1=read 0=write, 00 byte 01 half 10 word
//   d_addr/d_wdata      data address and write data
//   d_ack/d_err/d_rdata data completion pulse, error flag, zero-extended read
//   mem_mov/mem_rw/...  RAM strobe, direction, size, address, write data
//   mem_dout/mem_moc    RAM read data and operation-complete
//   busy                high whenever the sequencer is not idle
module mem_access_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15,
    parameter int FAIR    = 1
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic              f_err,
    output logic [DATA_W-1:0] f_data,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [1:0]        d_type,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_mov,
    output logic              mem_rw,
    output logic [1:0]        mem_type,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_moc,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_MOC, DONE, RELEASE} state_t;

    // The cycle counter counts MOV-high cycles, with the ISSUE cycle as the
    // first one. So MOV stays high for TIMEOUT cycles in total before an abort.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic              grant_data_reg, grant_data_next;  // 1 = data owns the port
    logic              last_data_reg, last_data_next;    // round-robin pointer
    logic              err_reg, err_next;
    logic [7:0]        cnt_reg, cnt_next;
    logic              mov_reg, mov_next;
    logic              rw_reg, rw_next;
    logic [1:0]        type_reg, type_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] din_reg, din_next;
    logic [DATA_W-1:0] f_data_reg, f_data_next;
    logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;

    logic              pick_data;
    logic [1:0]        sel_type;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_bad;

    function automatic logic misaligned(input logic [1:0] t, input logic [1:0] a);
        case (t)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = a[0];
            2'b10:   misaligned = (a != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] extend(input logic [1:0] t, input logic [DATA_W-1:0] w);
        case (t)
            2'b00:   extend = {{(DATA_W-8){1'b0}}, w[7:0]};
            2'b01:   extend = {{(DATA_W-16){1'b0}}, w[15:0]};
            default: extend = w;
        endcase
    endfunction

    // Data wins unless fetch is also asking and, in fair mode, data went last.
    assign pick_data = d_req && (!f_req || (FAIR == 0) || !last_data_reg);
    assign sel_type  = pick_data ? d_type : 2'b10;
    assign sel_addr  = pick_data ? d_addr : f_addr;
    assign sel_bad   = misaligned(sel_type, sel_addr[1:0]);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_reg      <= IDLE;
            grant_data_reg <= 1'b0;
            last_data_reg  <= 1'b0;
            err_reg        <= 1'b0;
            cnt_reg        <= '0;
            mov_reg        <= 1'b0;
            rw_reg         <= 1'b0;
            type_reg       <= '0;
            addr_reg       <= '0;
            din_reg        <= '0;
            f_data_reg     <= '0;
            d_rdata_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            grant_data_reg <= grant_data_next;
            last_data_reg  <= last_data_next;
            err_reg        <= err_next;
            cnt_reg        <= cnt_next;
            mov_reg        <= mov_next;
            rw_reg         <= rw_next;
            type_reg       <= type_next;
            addr_reg       <= addr_next;
            din_reg        <= din_next;
            f_data_reg     <= f_data_next;
            d_rdata_reg    <= d_rdata_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_data_next = grant_data_reg;
        last_data_next  = last_data_reg;
        err_next        = err_reg;
        cnt_next        = cnt_reg;
        mov_next        = mov_reg;
        rw_next         = rw_reg;
        type_next       = type_reg;
        addr_next       = addr_reg;
        din_next        = din_reg;
        f_data_next     = f_data_reg;
        d_rdata_next    = d_rdata_reg;
        case (state_reg)
            IDLE: begin
                if (f_req || d_req) begin
                    grant_data_next = pick_data;
                    last_data_next  = pick_data;
                    rw_next         = pick_data ? d_rw : 1'b1;
                    type_next       = sel_type;
                    addr_next       = sel_addr;
                    din_next        = pick_data ? d_wdata : '0;
                    if (sel_bad) begin
                        // Bad transfers never touch the RAM.
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        err_next   = 1'b0;
                        mov_next   = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_next   = 8'd1;
                state_next = WAIT_MOC;
            end
            WAIT_MOC: begin
                if (mem_moc) begin
                    mov_next   = 1'b0;
                    state_next = DONE;
                    if (!grant_data_reg) begin
                        f_data_next = mem_dout;
                    end else if (rw_reg) begin
                        d_rdata_next = extend(type_reg, mem_dout);
                    end
                end else if (cnt_reg >= CNT_LAST) begin
                    mov_next   = 1'b0;
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            DONE: begin
                state_next = RELEASE;
            end
            RELEASE: begin
                // A MOC still high from the last op must not start the next one.
                if (!mem_moc) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign f_ack    = (state_reg == DONE) && !grant_data_reg;
    assign d_ack    = (state_reg == DONE) && grant_data_reg;
    assign f_err    = f_ack && err_reg;
    assign d_err    = d_ack && err_reg;
    assign f_data   = f_data_reg;
    assign d_rdata  = d_rdata_reg;
    assign mem_mov  = mov_reg;
    assign mem_rw   = rw_reg;
    assign mem_type = type_reg;
    assign mem_addr = addr_reg;
    assign mem_din  = din_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Testbench for mem_access_arbiter. The bench RAM answers MOC one cycle after
// it sees MOV. Expected completions are queued when a request is driven. They
// are compared in order when f_ack or d_ack pulses.
module tb_mem_access_arbiter;

    logic        CLK;
    logic        CLR;
    logic        f_req, f_ack, f_err;
    logic [7:0]  f_addr;
    logic [31:0] f_data;
    logic        d_req, d_rw, d_ack, d_err;
    logic [1:0]  d_type;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        mem_mov, mem_rw, mem_moc, busy;
    logic [1:0]  mem_type;
    logic [7:0]  mem_addr;
    logic [31:0] mem_din, mem_dout;

    mem_access_arbiter #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(15), .FAIR(1)) dut (
        .CLK(CLK), .CLR(CLR),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_err(f_err), .f_data(f_data),
        .d_req(d_req), .d_rw(d_rw), .d_type(d_type), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .mem_mov(mem_mov), .mem_rw(mem_rw), .mem_type(mem_type), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_moc(mem_moc), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Bench RAM: one-cycle MOC response, plus a force used for the stale-MOC case.
    logic        ram_en, moc_force, model_moc;
    logic [31:0] ram_rdata;
    always @(posedge CLK) model_moc <= mem_mov & ram_en;
    assign mem_moc  = model_moc | moc_force;
    assign mem_dout = ram_rdata;

    typedef struct {
        logic        is_data;
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_f, exp_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic is_data, input logic err, input logic [31:0] data);
        exp_t e;
        e.is_data = is_data;
        e.err     = err;
        e.data    = data;
        exp_q.push_back(e);
    endtask

    // Monitor: count MOV cycles, capture the RAM command, score completions.
    int          mov_total = 0;
    logic        cap_rw;
    logic [1:0]  cap_type;
    logic [7:0]  cap_addr;
    logic [31:0] cap_din;
    always @(negedge CLK) begin
        if (mem_mov) begin
            mov_total <= mov_total + 1;
            cap_rw    <= mem_rw;
            cap_type  <= mem_type;
            cap_addr  <= mem_addr;
            cap_din   <= mem_din;
        end
        if (f_ack && d_ack) check("both_acks", 1, 0);
        if (f_ack || d_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 1, 0);
            end else begin
                check("ack_who", {31'b0, d_ack}, {31'b0, exp_q[0].is_data});
                check("ack_err", {31'b0, d_ack ? d_err : f_err}, {31'b0, exp_q[0].err});
                check("ack_data", d_ack ? d_rdata : f_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic xfer_f(input logic [7:0] addr, output int lat);
        logic got;
        got    = 1'b0;
        lat    = 0;
        f_addr = addr;
        f_req  = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge CLK);
            lat++;
            if (f_ack) got = 1'b1;
        end
        f_req = 1'b0;
        if (!got) check("f_ack_timeout", 0, 1);
    endtask

    task automatic xfer_d(input logic rw, input logic [1:0] t, input logic [7:0] addr,
                          input logic [31:0] wdata, output int lat);
        logic got;
        got     = 1'b0;
        lat     = 0;
        d_rw    = rw;
        d_type  = t;
        d_addr  = addr;
        d_wdata = wdata;
        d_req   = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge CLK);
            lat++;
            if (d_ack) got = 1'b1;
        end
        d_req = 1'b0;
        if (!got) check("d_ack_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 50 && !idle; i++) begin
            @(negedge CLK);
            if (!busy) idle = 1'b1;
        end
        check("return_idle", {31'b0, idle}, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int lat_f, lat_d, m0;
        CLR = 1'b1; f_req = 0; f_addr = 0; d_req = 0; d_rw = 0; d_type = 0;
        d_addr = 0; d_wdata = 0; ram_en = 1; moc_force = 0; ram_rdata = 0;
        exp_f = 0; exp_d = 0;
        repeat (3) @(negedge CLK);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_mov", {31'b0, mem_mov}, 0);
        check("rst_acks", {28'b0, f_ack, d_ack, f_err, d_err}, 0);
        check("rst_mem_cmd", {21'b0, mem_rw, mem_type, mem_addr}, 0);
        check("rst_mem_din", mem_din, 0);
        check("rst_f_data", f_data, 0);
        check("rst_d_rdata", d_rdata, 0);
        CLR = 1'b0;
        @(negedge CLK);

        // Fetch only: minimum latency, word read command.
        ram_rdata = 32'hE3A01005; exp_f = ram_rdata;
        push_exp(0, 0, exp_f);
        m0 = mov_total;
        xfer_f(8'h04, lat_f);
        #1;
        check("fetch_latency", lat_f, 3);
        check("fetch_mov_cycles", mov_total - m0, 2);
        check("fetch_cmd", {21'b0, cap_rw, cap_type, cap_addr}, {21'b0, 1'b1, 2'b10, 8'h04});
        wait_idle();

        // Contention after reset: data first, then fetch.
        ram_rdata = 32'hA5C39612; exp_d = 32'h12; exp_f = ram_rdata;
        push_exp(1, 0, exp_d);
        push_exp(0, 0, exp_f);
        fork
            xfer_d(1, 2'b00, 8'h21, 0, lat_d);
            xfer_f(8'h08, lat_f);
        join
        check("rr_data_first", {31'b0, lat_d < lat_f}, 1);
        wait_idle();
        // Data alone, then both: fetch now wins.
        ram_rdata = 32'hCAFEF00D; exp_d = ram_rdata;
        push_exp(1, 0, exp_d);
        xfer_d(1, 2'b10, 8'h08, 0, lat_d);
        wait_idle();
        ram_rdata = 32'h0BADC0DE; exp_f = ram_rdata; exp_d = 32'h0000C0DE;
        push_exp(0, 0, exp_f);
        push_exp(1, 0, exp_d);
        fork
            xfer_d(1, 2'b01, 8'h22, 0, lat_d);
            xfer_f(8'h0C, lat_f);
        join
        check("rr_fetch_first", {31'b0, lat_f < lat_d}, 1);
        wait_idle();

        // Byte read with zero-extension, then alignment errors (no MOV).
        ram_rdata = 32'h12345678; exp_d = 32'h00000078;
        push_exp(1, 0, exp_d);
        xfer_d(1, 2'b00, 8'h05, 0, lat_d);
        wait_idle();
        m0 = mov_total;
        push_exp(1, 1, exp_d);
        xfer_d(1, 2'b10, 8'h06, 0, lat_d);
        wait_idle();
        push_exp(1, 1, exp_d);
        xfer_d(1, 2'b01, 8'h03, 0, lat_d);
        wait_idle();
        push_exp(1, 1, exp_d);
        xfer_d(1, 2'b11, 8'h00, 0, lat_d);
        wait_idle();
        push_exp(0, 1, exp_f);
        xfer_f(8'h02, lat_f);
        wait_idle();
        #1;
        check("misaligned_no_mov", mov_total - m0, 0);

        // RAM never answers: MOV high for TIMEOUT cycles, then error ack.
        ram_en = 1'b0;
        m0 = mov_total;
        push_exp(1, 1, exp_d);
        xfer_d(1, 2'b10, 8'h20, 0, lat_d);
        check("timeout_mov_low_at_ack", {31'b0, mem_mov}, 0);
        #1;
        check("timeout_mov_cycles", mov_total - m0, 15);
        wait_idle();
        ram_en = 1'b1;

        // Word write: command and data reach the RAM unchanged.
        push_exp(1, 0, exp_d);
        xfer_d(0, 2'b10, 8'h10, 32'hDEADBEEF, lat_d);
        check("write_cmd", {21'b0, cap_rw, cap_type, cap_addr}, {21'b0, 1'b0, 2'b10, 8'h10});
        check("write_din", cap_din, 32'hDEADBEEF);
        wait_idle();

        // Reset during WAIT_MOC with MOC stuck high.
        ram_en = 1'b0;
        d_rw = 1; d_type = 2'b10; d_addr = 8'h30; d_req = 1'b1;
        repeat (4) @(negedge CLK);
        check("pre_clr_mov", {31'b0, mem_mov}, 1);
        moc_force = 1'b1;
        CLR = 1'b1;
        d_req = 1'b0;
        @(negedge CLK);
        check("clr_mov_drop", {31'b0, mem_mov}, 0);
        check("clr_idle", {31'b0, busy}, 0);
        check("clr_no_ack", {30'b0, f_ack, d_ack}, 0);
        check("clr_d_rdata", d_rdata, 0);
        CLR = 1'b0;
        exp_f = 0; exp_d = 0;
        ram_en = 1'b1;
        @(negedge CLK);
        ram_rdata = 32'h11223344; exp_f = ram_rdata;
        push_exp(0, 0, exp_f);
        xfer_f(8'h0C, lat_f);
        check("post_clr_latency", lat_f, 3);
        moc_force = 1'b0;
        wait_idle();

        repeat (3) @(negedge CLK);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
